// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive paths.
//   tx_state_t        transmitter FSM state encoding
//   UART_IDLE_LEVEL   line level while idle and during stop bits
//   UART_START_LEVEL  line level of the start bit
//   uart_parity()     parity over the low nbits of a data word, inverted when odd
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL    = 1'b1;
    localparam logic UART_START_LEVEL   = 1'b0;
    localparam int   UART_MAX_DATA_BITS = 8;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic uart_parity(
        input logic [UART_MAX_DATA_BITS-1:0] data,
        input int                            nbits,
        input logic                          odd
    );
        logic p;
        p = odd;
        for (int i = 0; i < UART_MAX_DATA_BITS; i++) begin
            if (i < nbits) begin
                p = p ^ data[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: host-side byte handshake of the UART transmitter.
//   tx_data   byte to send, sampled only on the accept cycle
//   tx_valid  host has a byte
//   tx_ready  transmitter can take tx_data this cycle
//   master: host side, slave: transmitter side
interface uart_transmitter_if #(
    parameter int DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/counter.sv
// counter: generic up-counter with synchronous clear.
//   clk    clock
//   rst    synchronous active-high reset, count -> 0
//   clr    clear to zero this cycle (wins over en)
//   en     increment this cycle
//   count  current value
module counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises bytes onto an idle-high UART line
// (start bit, DATA_BITS data LSB first, optional parity, STOP_BITS stop bits),
// each bit CLKS_PER_BIT clocks long, frames back-to-back when data keeps coming.
//   clk           peripheral clock
//   rst           synchronous active-high reset, aborts any frame in flight
//   tx_if         slave side of the byte handshake (tx_data/tx_valid/tx_ready)
//   tx_bitstream  registered serial line
//   active_tx     high while a frame is on the line
//   done          one-cycle pulse in the last clock of the final stop bit
//
// state     | meaning
// ----------+-----------------------------------------------
// TX_IDLE   | line high, ready for a byte
// TX_START  | driving the low start bit
// TX_DATA   | driving shift_q[0], shifting right at each bit end
// TX_PARITY | driving the parity bit captured on accept
// TX_STOP   | driving high stop bit(s); may accept the next byte
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    uart_transmitter_if.slave tx_if,
    output logic              tx_bitstream,
    output logic              active_tx,
    output logic              done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = 4;

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 line_q, line_d;
    logic                 active_q, active_d;
    logic                 done_q, done_d;

    logic [CNT_W-1:0]     clk_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 tc;
    logic                 data_last;
    logic                 stop_last;
    logic                 final_stop_tc;
    logic                 ready;
    logic                 accept;
    logic                 clk_clr;
    logic                 clk_en;
    logic                 bit_clr;
    logic                 bit_en;

    assign tc            = (state_q != TX_IDLE) && (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign data_last     = (bit_cnt == BIT_W'(DATA_BITS - 1));
    assign stop_last     = (bit_cnt == BIT_W'(STOP_BITS - 1));
    assign final_stop_tc = (state_q == TX_STOP) && stop_last && tc;

    // Ready in the final stop clock lets the next frame start with no idle gap.
    assign ready          = !rst && ((state_q == TX_IDLE) || final_stop_tc);
    assign tx_if.tx_ready = ready;
    assign accept         = tx_if.tx_valid && ready;

    assign clk_clr = accept || tc || (state_q == TX_IDLE);
    assign clk_en  = (state_q != TX_IDLE);

    // Bit counter is shared by DATA and STOP; it is zeroed between phases.
    assign bit_en  = tc && ((state_q == TX_DATA) || (state_q == TX_STOP));
    assign bit_clr = accept || (state_q == TX_IDLE)
                  || ((state_q == TX_DATA) && tc && data_last)
                  || final_stop_tc;

    counter #(.WIDTH(CNT_W)) u_clk_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clk_clr),
        .en    (clk_en),
        .count (clk_cnt)
    );

    counter #(.WIDTH(BIT_W)) u_bit_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bit_clr),
        .en    (bit_en),
        .count (bit_cnt)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        parity_d = parity_q;

        case (state_q)
            TX_IDLE: begin
                state_d = TX_IDLE;
            end
            TX_START: begin
                if (tc) begin
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tc) begin
                    if (data_last) begin
                        state_d = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                    end
                end
            end
            TX_PARITY: begin
                if (tc) begin
                    state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (final_stop_tc) begin
                    state_d = TX_IDLE;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        if (accept) begin
            state_d  = TX_START;
            shift_d  = tx_if.tx_data;
            parity_d = uart_parity(UART_MAX_DATA_BITS'(tx_if.tx_data), DATA_BITS,
                                   1'(PARITY_ODD));
        end

        // Line level follows the next state so the output is a single flop.
        case (state_d)
            TX_START:  line_d = UART_START_LEVEL;
            TX_DATA:   line_d = shift_d[0];
            TX_PARITY: line_d = parity_d;
            default:   line_d = UART_IDLE_LEVEL;
        endcase

        active_d = (state_d != TX_IDLE);

        // Registered done: raise it one clock early so it lands on the final stop clock.
        done_d = (state_q == TX_STOP) && stop_last
              && (clk_cnt == CNT_W'(CLKS_PER_BIT - 2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= TX_IDLE;
            shift_q  <= '0;
            parity_q <= 1'b0;
            line_q   <= UART_IDLE_LEVEL;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            line_q   <= line_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign tx_bitstream = line_q;
    assign active_tx    = active_q;
    assign done         = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: four transmitter configurations run side by side.
// Stimulus pushes each accepted byte (with its accept cycle) into a per-config
// queue; a monitor pops it when the frame should start and compares the line,
// tx_ready, active_tx and done every cycle against a frame built from the
// byte, then compares the mid-bit samples of the whole frame at its end.
module tb_uart_transmitter;

    typedef struct {
        int n;
        int data;
    } exp_t;

    logic clk = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // fields: 0 CLKS_PER_BIT, 1 DATA_BITS, 2 PARITY_EN, 3 PARITY_ODD, 4 STOP_BITS, 5 frames
    function automatic int cfg(input int idx, input int fld);
        logic [47:0] row;
        case (idx)
            0:       row = {8'd16, 8'd8, 8'd0, 8'd0, 8'd1, 8'd8};
            1:       row = {8'd16, 8'd8, 8'd1, 8'd0, 8'd1, 8'd8};
            2:       row = {8'd4,  8'd7, 8'd0, 8'd0, 8'd2, 8'd14};
            default: row = {8'd16, 8'd8, 8'd1, 8'd1, 8'd1, 8'd8};
        endcase
        return int'(row[8*(5-fld) +: 8]);
    endfunction

    // Bit i of the result is the line level during bit period i of the frame.
    function automatic logic [15:0] frame_bits(input int data, input int db,
                                               input int pe, input int po);
        logic [15:0] v;
        int          ones;
        v    = '1;
        v[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < db; i++) begin
            v[1+i] = data[i];
            if (data[i]) ones++;
        end
        if (pe != 0) v[1+db] = ((ones % 2) == 1) ^ (po != 0);
        return v;
    endfunction

    task automatic check(input string nm, input int g, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s cfg%0d cycle %0d: got %0d, expected %0d",
                         nm, g, cyc, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
        localparam int CPB  = cfg(gi, 0);
        localparam int DB   = cfg(gi, 1);
        localparam int PE   = cfg(gi, 2);
        localparam int PO   = cfg(gi, 3);
        localparam int SB   = cfg(gi, 4);
        localparam int NFR  = cfg(gi, 5);
        localparam int NB   = 1 + DB + PE + SB;
        localparam int F    = CPB * NB;
        localparam int MASK = (1 << DB) - 1;
        localparam logic [15:0] NBMASK = 16'((32'd1 << NB) - 1);

        logic        rst;
        logic        line;
        logic        act;
        logic        dn;
        exp_t        q[$];
        exp_t        cur;
        bit          cur_v   = 1'b0;
        logic [15:0] cap     = '1;
        logic [15:0] ebits   = '1;
        int          free_at = 0;
        int          sent    = 0;
        int          got     = 0;
        bit          fin     = 1'b0;

        uart_transmitter_if #(.DATA_BITS(DB)) bus ();

        uart_transmitter #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (DB),
            .PARITY_EN    (PE),
            .PARITY_ODD   (PO),
            .STOP_BITS    (SB)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .tx_if        (bus),
            .tx_bitstream (line),
            .active_tx    (act),
            .done         (dn)
        );

        initial begin : stim
            int   d;
            int   gap;
            int   f;
            int   n;
            int   dir[$];
            exp_t e;
            if (gi == 0) dir = '{8'h55, 8'hA5, 8'h3C};
            else if (PE != 0) dir = '{8'h07};
            rst          = 1'b1;
            bus.tx_valid = 1'b0;
            bus.tx_data  = '0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            gap = 0;
            f   = 0;
            while (f < NFR) begin
                if (cyc >= free_at) begin
                    if (gap > 0) begin
                        bus.tx_valid = 1'b0;
                        bus.tx_data  = DB'($urandom);
                        gap--;
                    end else begin
                        d = (f < dir.size()) ? dir[f] : int'($urandom & MASK);
                        bus.tx_valid = 1'b1;
                        bus.tx_data  = DB'(d);
                        e.n = cyc;
                        e.data = d;
                        q.push_back(e);
                        free_at = cyc + F;
                        sent++;
                        if (gi == 0 && f == 0) gap = 3;
                        else if (gi == 0 && f == 1) gap = 0;
                        else gap = ($urandom_range(0, 4) < 2) ? 0 : int'($urandom_range(1, 4));
                        f++;
                    end
                end else begin
                    // Busy: random valid pulses and data changes must be ignored.
                    bus.tx_valid = ($urandom_range(0, 3) == 0);
                    bus.tx_data  = DB'($urandom);
                end
                @(posedge clk); #1;
            end

            if (gi == 0) begin
                bus.tx_valid = 1'b0;
                while (cyc < free_at) begin @(posedge clk); #1; end
                d = int'($urandom & MASK);
                n = cyc;
                bus.tx_valid = 1'b1;
                bus.tx_data  = DB'(d);
                e.n = n;
                e.data = d;
                q.push_back(e);
                @(posedge clk); #1;
                bus.tx_valid = 1'b0;
                // Abort in the middle of data bit 3.
                while (cyc < n + 1 + 4*CPB + 3) begin @(posedge clk); #1; end
                rst = 1'b1;
                repeat (2) begin @(posedge clk); #1; end
                rst = 1'b0;
                free_at = cyc;
                repeat (20) begin @(posedge clk); #1; end
                d = int'($urandom & MASK);
                bus.tx_valid = 1'b1;
                bus.tx_data  = DB'(d);
                e.n = cyc;
                e.data = d;
                q.push_back(e);
                free_at = cyc + F;
                sent++;
                @(posedge clk); #1;
            end

            bus.tx_valid = 1'b0;
            while (cyc < free_at + 4) begin @(posedge clk); #1; end
            check("frames_completed", gi, got, sent);
            check("queue_left", gi, q.size() + int'(cur_v), 0);
            fin = 1'b1;
        end

        always @(negedge clk) begin : mon
            int   c;
            int   k;
            logic e_line;
            logic e_act;
            logic e_done;
            logic e_rdy;
            if (cyc >= 1) begin
                c = cyc;
                if (!cur_v && q.size() > 0 && q[0].n + 1 <= c) begin
                    cur   = q.pop_front();
                    cur_v = 1'b1;
                    cap   = '1;
                    ebits = frame_bits(cur.data, DB, PE, PO);
                end
                e_line = 1'b1;
                e_act  = 1'b0;
                e_done = 1'b0;
                e_rdy  = !rst;
                if (cur_v && c >= cur.n + 1) begin
                    k      = c - cur.n - 1;
                    e_line = ebits[k / CPB];
                    e_act  = 1'b1;
                    e_done = (c == cur.n + F);
                    if (c < cur.n + F) e_rdy = 1'b0;
                    if ((k % CPB) == (CPB / 2)) cap[k / CPB] = line;
                end
                check("tx_bitstream", gi, int'(line), int'(e_line));
                check("tx_ready", gi, int'(bus.tx_ready), int'(e_rdy));
                check("active_tx", gi, int'(act), int'(e_act));
                check("done", gi, int'(dn), int'(e_done));
                if (cur_v && c == cur.n + F) begin
                    check("frame_bits", gi, int'(cap & NBMASK), int'(ebits & NBMASK));
                    got++;
                    cur_v = 1'b0;
                end
                if (rst) begin
                    cur_v = 1'b0;
                    q.delete();
                end
            end
        end
    end

    initial begin
        while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin)
               && cyc < 40000)
            @(posedge clk);
        if (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: stimulus not finished at cycle %0d, required by 40000", cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serialises parallel bytes onto an asynchronous UART line using the same framing the receive path expects: idle-high line, one low start bit, data LSB first, optional parity, and one or two high stop bits. Each bit is exactly `CLKS_PER_BIT` clocks long. The block sits on the TX pin side of the UART core, opposite the receiver. It takes bytes from the host through a valid/ready handshake and streams frames back-to-back with no idle gap when data is continuously available.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: clocks per bit period; legal range ≥ 2.
- `DATA_BITS`, 8: data bits per frame; legal range 5..8.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

Ports:
- `clk`  in  1  peripheral clock; the only clock in the block.
- `rst`  in  1  reset; synchronous, active-high.
- `tx_data`  in  `DATA_BITS`  byte to send; sampled only on the accept cycle.
- `tx_valid`  in  1  host has data; may be withdrawn before acceptance.
- `tx_ready`  out  1  block can accept `tx_data` this cycle.
- `tx_bitstream`  out  1  serial line; registered, glitch-free.
- `active_tx`  out  1  high while a frame is being driven (any state other than IDLE).
- `done`  out  1  one-cycle pulse in the last clock of the final stop bit.

## Operation
- FSM states are IDLE, START, DATA, PARITY and STOP.
  - PARITY is skipped when `PARITY_EN`=0.
  - STOP runs for `STOP_BITS` bit periods.
- Accept occurs when `tx_valid && tx_ready`. On accept:
  - `tx_data` loads into a shift register.
  - The parity bit is computed from `tx_data`: XOR of the data bits, XOR `PARITY_ODD`.
  - The FSM moves to START.
- Timing counter runs 0..`CLKS_PER_BIT`-1 in every non-IDLE state.
  - Terminal count (tc) advances the bit.
  - The counter is cleared on accept.
- DATA shifts right at each tc; `tx_bitstream` is driven from bit 0 of the shift register.
- Bit counter counts DATA bits 0..`DATA_BITS`-1 and STOP bits 0..`STOP_BITS`-1.
- `tx_ready` = (IDLE) OR (STOP AND last stop bit AND tc). It is 0 while `rst` is high.
- Accept during the final stop tc goes directly to START, giving zero gap between frames. Otherwise the FSM returns to IDLE.
- `tx_valid` or `tx_data` changes while busy are ignored. No data is queued beyond the single accepted byte.
- Reset mid-frame aborts the frame immediately and the byte is discarded. The truncated frame is acceptable because the receiver flags a framing error.

## Timing
- Reset values: `tx_bitstream`=1, `tx_ready`=0 during reset, `active_tx`=0, `done`=0, FSM=IDLE, counters=0.
- In the first cycle after `rst` deasserts: `tx_ready`=1.
- Latency: if accept happens in cycle N, `tx_bitstream` is low from cycle N+1 through N+`CLKS_PER_BIT`.
- Frame length F = `CLKS_PER_BIT`·(1+`DATA_BITS`+`PARITY_EN`+`STOP_BITS`). The line holds each bit for exactly `CLKS_PER_BIT` cycles.
- `done` and the second-window `tx_ready` are both asserted in cycle N+F.
  - If that cycle accepts, the next start bit begins in cycle N+F+1.
  - Otherwise `tx_bitstream` stays 1 and `tx_ready` stays 1.
- `active_tx` is high from N+1 through N+F, and stays high continuously across back-to-back frames.

## Structure
- Shared package `uart_pkg` holds:
  - the `tx_state_t` enum;
  - line-level constants `UART_IDLE_LEVEL`=1, `UART_START_LEVEL`=0;
  - the parity helper function, shared with the receiver.
- Sub-module: reuse the codebase `counter` for the timing counter (load = clear on accept/tc) and for the bit counter.
- Shift register, parity and FSM stay in `uart_transmitter`. Output is a single flop on `tx_bitstream`.

## Test plan
- Defaults, send 0x55:
  - Line reads 0,1,0,1,0,1,0,1,0,1, each level held 16 cycles.
  - `done` fires in cycle N+160.
  - `tx_ready` returns to 1 after.
- Back-to-back 0xA5 then 0x3C, `tx_valid` held high:
  - Second accept happens in cycle N+160.
  - Second start bit begins at N+161 with no high gap.
  - Bits decode LSB first.
- `PARITY_EN`=1 with 0x07:
  - Even parity bit = 1; odd parity bit = 0.
  - F = 176.
- `DATA_BITS`=7, `STOP_BITS`=2, `CLKS_PER_BIT`=4:
  - F = 40.
  - Both stop bits high.
  - `done` fires only at the end of the second stop bit.
- Change `tx_data` and pulse `tx_valid` mid-frame:
  - `tx_ready`=0 throughout.
  - The original byte is transmitted unchanged.
  - No extra frame is sent.
- Assert `rst` during DATA bit 3:
  - `tx_bitstream`=1 in the next cycle.
  - `active_tx`=0 and `done` never pulses.
  - After release, `tx_ready`=1 and no frame is sent.
